uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_tx.sv | 59 +++++
 rtl/uart_tx_arbiter.sv | 147 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encodings,
// default bit timing and frame geometry.
package uart_pkg;

  // Arbiter FSM state encodings
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  // Default clock cycles per serial bit
  localparam int DEFAULT_CLKS_PER_BIT = 1000;

  // 8N1 frame: start + 8 data + stop
  localparam int FRAME_BITS = 10;

endpackage

// File: rtl/uart_tx.sv
// 8N1 serial shifter. A write pulse loads a byte; busy rises on the next
// cycle and stays high for exactly FRAME_BITS*CLKS_PER_BIT cycles while the
// frame goes out LSB first. The line idles high and returns high on reset.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we,
  input  logic [7:0] din,
  output logic       busy,
  output logic       tx
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CNT_W-1:0] clk_cnt_reg;
  logic [3:0]       bit_cnt_reg;
  logic [8:0]       shift_reg;   // remaining data bits plus the stop bit
  logic             busy_reg;
  logic             tx_reg;

  // Bit timing and shift-out; a write starts the start bit on the next cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_cnt_reg <= '0;
      bit_cnt_reg <= '0;
      shift_reg   <= '1;
      busy_reg    <= 1'b0;
      tx_reg      <= 1'b1;
    end else if (we) begin
      clk_cnt_reg <= '0;
      bit_cnt_reg <= '0;
      shift_reg   <= {1'b1, din};
      busy_reg    <= 1'b1;
      tx_reg      <= 1'b0;
    end else if (busy_reg) begin
      if (clk_cnt_reg == CNT_W'(CLKS_PER_BIT - 1)) begin
        clk_cnt_reg <= '0;
        if (bit_cnt_reg == 4'(FRAME_BITS - 1)) begin
          busy_reg <= 1'b0;
          tx_reg   <= 1'b1;
        end else begin
          tx_reg      <= shift_reg[0];
          shift_reg   <= {1'b1, shift_reg[8:1]};
          bit_cnt_reg <= bit_cnt_reg + 4'd1;
        end
      end else begin
        clk_cnt_reg <= clk_cnt_reg + 1'b1;
      end
    end
  end

  assign busy = busy_reg;
  assign tx   = tx_reg;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ
// requesters. A granted owner keeps the channel until its last byte has
// gone out, or until it idles for LOCK_TIMEOUT cycles between bytes.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy,
  output logic                 tx
);

  localparam int PTR_W  = $clog2(NUM_REQ);
  localparam int HOLD_W = $clog2(LOCK_TIMEOUT + 1);

  logic [1:0]         state_reg, state_next;
  logic [NUM_REQ-1:0] grant_reg, grant_next;
  logic [PTR_W-1:0]   owner_reg, owner_next;
  logic [PTR_W-1:0]   rr_ptr_reg, rr_ptr_next;
  logic               last_reg, last_next;
  logic [HOLD_W-1:0]  hold_cnt_reg, hold_cnt_next;

  logic [7:0]         data_arr [NUM_REQ];
  logic [PTR_W-1:0]   cand_idx [NUM_REQ];
  logic [NUM_REQ-1:0] cand_valid;
  logic [PTR_W-1:0]   win_idx;
  logic               win_found;
  logic [PTR_W-1:0]   owner_inc;
  logic               tx_we;
  logic               tx_busy;

  // Per-requester byte lanes and the search order starting at rr_ptr
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    logic [PTR_W:0] sum;
    assign data_arr[gi]   = req_data[8*gi +: 8];
    assign sum            = {1'b0, rr_ptr_reg} + (PTR_W+1)'(gi);
    assign cand_idx[gi]   = (sum >= (PTR_W+1)'(NUM_REQ)) ?
                            PTR_W'(sum - (PTR_W+1)'(NUM_REQ)) : PTR_W'(sum);
    assign cand_valid[gi] = req_valid[cand_idx[gi]];
  end

  // First valid requester at or after rr_ptr, wrapping
  always_comb begin
    win_idx   = '0;
    win_found = |cand_valid;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (cand_valid[k]) win_idx = cand_idx[k];
    end
  end

  assign owner_inc = (owner_reg == PTR_W'(NUM_REQ - 1)) ? '0 : owner_reg + 1'b1;

  // Next-state logic: arbitration, byte load, frame wait and lock hold
  always_comb begin
    state_next    = state_reg;
    grant_next    = grant_reg;
    owner_next    = owner_reg;
    rr_ptr_next   = rr_ptr_reg;
    last_next     = last_reg;
    hold_cnt_next = hold_cnt_reg;
    tx_we         = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (win_found) begin
          grant_next = NUM_REQ'(1) << win_idx;
          owner_next = win_idx;
          state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        tx_we      = 1'b1;
        last_next  = req_last[owner_reg];
        state_next = ST_SEND;
      end
      ST_SEND: begin
        if (!tx_busy) begin
          if (last_reg) begin
            grant_next  = '0;
            rr_ptr_next = owner_inc;
            state_next  = ST_IDLE;
          end else if (req_valid[owner_reg]) begin
            state_next = ST_LOAD;
          end else begin
            hold_cnt_next = '0;
            state_next    = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (req_valid[owner_reg]) begin
          state_next = ST_LOAD;
        end else if (hold_cnt_reg == HOLD_W'(LOCK_TIMEOUT - 1)) begin
          grant_next  = '0;
          rr_ptr_next = owner_inc;
          state_next  = ST_IDLE;
        end else begin
          hold_cnt_next = hold_cnt_reg + 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      grant_reg    <= '0;
      owner_reg    <= '0;
      rr_ptr_reg   <= '0;
      last_reg     <= 1'b0;
      hold_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      grant_reg    <= grant_next;
      owner_reg    <= owner_next;
      rr_ptr_reg   <= rr_ptr_next;
      last_reg     <= last_next;
      hold_cnt_reg <= hold_cnt_next;
    end
  end

  uart_tx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_uart_tx (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (tx_we),
    .din   (data_arr[owner_reg]),
    .busy  (tx_busy),
    .tx    (tx)
  );

  assign req_ready = (state_reg == ST_LOAD) ? grant_reg : '0;
  assign grant     = grant_reg;
  assign busy      = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with CLKS_PER_BIT=4, NUM_REQ=4,
// LOCK_TIMEOUT=16. Requesters are modelled as byte queues; a line decoder
// rebuilds transmitted bytes from tx.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ = 4;
  localparam int CPB     = 4;
  localparam int LOCK    = 16;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NUM_REQ-1:0]   req_valid = '0;
  logic [8*NUM_REQ-1:0] req_data = '0;
  logic [NUM_REQ-1:0]   req_last = '0;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ-1:0]   grant;
  logic                 busy;
  logic                 tx;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ      (NUM_REQ),
    .CLKS_PER_BIT (CPB),
    .LOCK_TIMEOUT (LOCK)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .grant     (grant),
    .busy      (busy),
    .tx        (tx)
  );

  int check_cnt = 0;
  int pass_cnt  = 0;

  bit [8:0] rq [NUM_REQ][$];   // {last, data} pending per requester
  int cyc = 0;
  int ready_cnt [NUM_REQ];
  int bad_ready = 0;
  int grant_log [$];
  int prev_grant = 0;
  int load_idx [$];
  int load_cyc [$];
  int rx_q [$];                // decoded bytes, -1 for a bad stop bit
  bit rx_active = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
  endtask

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic drive();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rq[i].size() > 0) begin
        req_valid[i]       = 1'b1;
        req_data[8*i +: 8] = rq[i][0][7:0];
        req_last[i]        = rq[i][0][8];
      end else begin
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
      end
    end
  endtask

  task automatic push(input int i, input logic [7:0] d, input logic last);
    rq[i].push_back({last, d});
    drive();
  endtask

  // One clock: log handshakes, advance to the next falling edge, pop accepted bytes
  task automatic tick();
    logic [NUM_REQ-1:0] rdy;
    rdy = req_ready;
    if ((rdy & ~grant) != '0) bad_ready++;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rdy[i]) begin
        ready_cnt[i]++;
        load_idx.push_back(i);
        load_cyc.push_back(cyc);
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rdy[i] && rq[i].size() > 0) void'(rq[i].pop_front());
    end
    if (int'(grant) != prev_grant && grant != '0) grant_log.push_back(int'(grant));
    prev_grant = int'(grant);
    drive();
  endtask

  task automatic clear_logs();
    grant_log.delete();
    load_idx.delete();
    load_cyc.delete();
    rx_q.delete();
    for (int i = 0; i < NUM_REQ; i++) ready_cnt[i] = 0;
    bad_ready = 0;
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < NUM_REQ; i++) if (rq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (!(busy == 1'b0 && all_empty() && !rx_active)) begin
      tick();
      n++;
      if (n > 600) begin
        check({tag, "_timeout"}, 32'd1, 32'd0);
        break;
      end
    end
    tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) rq[i].delete();
    drive();
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Line decoder: samples each bit mid-period, drops frames cut by reset
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx === 1'b0) begin
        bit ab;
        logic [7:0] d;
        logic stop;
        rx_active = 1'b1;
        ab = 1'b0;
        d = '0;
        stop = 1'b0;
        for (int k = 0; k < 37; k++) begin
          @(negedge clk);
          if (rst_n !== 1'b1) ab = 1'b1;
          if (k >= 4 && k <= 32 && (k % 4) == 0) d[(k - 4) / 4] = tx;
          if (k == 36) stop = tx;
        end
        if (!ab) rx_q.push_back(stop === 1'b1 ? int'(d) : -1);
        rx_active = 1'b0;
      end
    end
  end

  // Global time bound
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [9:0] t1_bits;
    int zeros;
    t1_bits = 10'b1101001010;  // line levels for 0xA5, first bit in bit 0
    @(negedge clk);

    // Reset state
    repeat (3) tick();
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", req_ready, 0);
    check("rst_tx", tx, 1);
    rst_n = 1'b1;
    tick();

    // Single byte 0xA5 from requester 2
    clear_logs();
    push(2, 8'hA5, 1'b1);
    tick();
    check("t1_grant", grant, 4'b0100);
    check("t1_ready", req_ready, 4'b0100);
    tick();
    tick();
    for (int b = 0; b < 10; b++) begin
      if (b > 0) repeat (CPB) tick();
      check($sformatf("t1_tx_bit%0d", b), tx, t1_bits[b]);
    end
    wait_idle("t1");
    check("t1_release", grant, 0);
    check("t1_ready_pulses", ready_cnt[2], 1);
    check("t1_rx", qget(rx_q, 0), 32'hA5);

    // rr_ptr now 3: requester 3 beats requester 2
    clear_logs();
    push(2, 8'h01, 1'b1);
    push(3, 8'h02, 1'b1);
    wait_idle("t1b");
    check("t1b_grant0", qget(grant_log, 0), 4'b1000);
    check("t1b_grant1", qget(grant_log, 1), 4'b0100);
    check("t1b_rx0", qget(rx_q, 0), 32'h02);
    check("t1b_rx1", qget(rx_q, 1), 32'h01);

    // Contention after reset: 0 wins, then 3 before 0's re-request
    do_reset();
    clear_logs();
    push(0, 8'h30, 1'b1);
    push(3, 8'h33, 1'b1);
    tick();
    check("t2_first_grant", grant, 4'b0001);
    tick();
    push(0, 8'h31, 1'b1);
    wait_idle("t2");
    check("t2_grant_cnt", grant_log.size(), 3);
    check("t2_grant1", qget(grant_log, 1), 4'b1000);
    check("t2_grant2", qget(grant_log, 2), 4'b0001);
    check("t2_rx0", qget(rx_q, 0), 32'h30);
    check("t2_rx1", qget(rx_q, 1), 32'h33);
    check("t2_rx2", qget(rx_q, 2), 32'h31);

    // Locked three-byte message from 1 while 0 waits
    clear_logs();
    push(1, 8'h10, 1'b0);
    push(1, 8'h11, 1'b0);
    push(1, 8'h12, 1'b1);
    push(0, 8'h40, 1'b1);
    wait_idle("t3");
    check("t3_grant0", qget(grant_log, 0), 4'b0010);
    check("t3_grant1", qget(grant_log, 1), 4'b0001);
    check("t3_load_order", {qget(load_idx, 0), qget(load_idx, 1), qget(load_idx, 2), qget(load_idx, 3)} & 32'hFF,
          32'h00);
    check("t3_load_idx2", qget(load_idx, 2), 1);
    check("t3_load_idx3", qget(load_idx, 3), 0);
    check("t3_spacing1", qget(load_cyc, 1) - qget(load_cyc, 0), 42);
    check("t3_spacing2", qget(load_cyc, 2) - qget(load_cyc, 1), 42);
    check("t3_rx0", qget(rx_q, 0), 32'h10);
    check("t3_rx1", qget(rx_q, 1), 32'h11);
    check("t3_rx2", qget(rx_q, 2), 32'h12);
    check("t3_rx3", qget(rx_q, 3), 32'h40);
    check("t3_nonowner_ready", bad_ready, 0);
    check("t3_ready_cnt1", ready_cnt[1], 3);

    // Lock timeout: 1 sends one non-final byte then goes quiet, 2 waits
    clear_logs();
    push(1, 8'h55, 1'b0);
    push(2, 8'h66, 1'b1);
    wait_idle("t4");
    check("t4_load_idx0", qget(load_idx, 0), 1);
    check("t4_load_idx1", qget(load_idx, 1), 2);
    check("t4_hold_span", qget(load_cyc, 1) - qget(load_cyc, 0), 59);
    check("t4_grant1", qget(grant_log, 1), 4'b0100);
    check("t4_rx0", qget(rx_q, 0), 32'h55);
    check("t4_rx1", qget(rx_q, 1), 32'h66);
    check("t4_nonowner_ready", bad_ready, 0);

    // Reset during data bit 4 of a frame
    clear_logs();
    push(3, 8'h2C, 1'b1);
    tick();
    check("t5_ready", req_ready, 4'b1000);
    repeat (22) tick();
    check("t5_tx_bit4", tx, 0);
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("t5_tx_rst%0d", k), tx, 1);
    end
    check("t5_grant_rst", grant, 0);
    check("t5_busy_rst", busy, 0);
    rst_n = 1'b1;
    zeros = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (tx !== 1'b1) zeros++;
    end
    check("t5_tx_idle_after", zeros, 0);
    push(0, 8'h81, 1'b1);
    wait_idle("t5");
    check("t5_rx_cnt", rx_q.size(), 1);
    check("t5_rx0", qget(rx_q, 0), 32'h81);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
